reg_sync_scheduler: RTL and testbench



---
 rtl/reg_sync_pkg.sv | 23 ++
 rtl/reg_sync_scheduler_rr_pick.sv | 28 ++
 rtl/reg_sync_scheduler.sv | 103 ++++++++++
 tb/tb_reg_sync_scheduler.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/reg_sync_pkg.sv
// Shared types and helpers for the register-write scheduler.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package reg_sync_pkg;

  // Two-bit encoding leaves spare codes, which the FSM folds back to IDLE.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1
  } state_t;

  // Width of a source index; at least one bit even for tiny N.
  function automatic int src_width(input int n);
    if (n <= 2) return 1;
    return $clog2(n);
  endfunction

  // Register-file address that source i is mirrored to.
  function automatic int src_addr(input int base, input int i);
    return base + i;
  endfunction

endpackage

// File: rtl/reg_sync_scheduler_rr_pick.sv
// Combinational round-robin picker: first set pending bit at or above ptr, wrapping.
// Latency: combinational.
// Backpressure: none; the caller decides whether to act on the pick.
// Ports: pending (one bit per source), ptr (search start), any (some bit set), idx (chosen source).
module reg_sync_scheduler_rr_pick #(
  parameter int N_SRC = 4,
  parameter int SRC_W = 2
) (
  input  logic [N_SRC-1:0] pending,
  input  logic [SRC_W-1:0] ptr,
  output logic             any,
  output logic [SRC_W-1:0] idx
);

  int j;

  // Walk offsets from farthest to nearest so the nearest pending index wins.
  always_comb begin
    any = |pending;
    idx = '0;
    j   = 0;
    for (int k = N_SRC - 1; k >= 0; k--) begin
      j = (int'(ptr) + k) % N_SRC;
      if (pending[j]) idx = SRC_W'(j);
    end
  end

endmodule

// File: rtl/reg_sync_scheduler.sv
// Mirrors N_SRC source registers into the register file through its single write port.
// Latency: change to we_system is 1 clk when idle and at the round-robin head; 1 write per 2 clk max.
// Backpressure: the write is held stable until wr_ready; en=0 only blocks new grants.
// Ports: clk, rst (sync, active-high), en, force_sync, src_val (packed sources), wr_ready,
//        we_system/waddr/wdata (registered write port), busy (in WRITE), cur_src (last granted source).
module reg_sync_scheduler
  import reg_sync_pkg::*;
#(
  parameter int N_SRC     = 4,
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 5,
  parameter int BASE_ADDR = 0,
  parameter int SRC_W     = src_width(N_SRC)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    force_sync,
  input  logic [N_SRC*DATA_W-1:0] src_val,
  input  logic                    wr_ready,
  output logic                    we_system,
  output logic [ADDR_W-1:0]       waddr,
  output logic [DATA_W-1:0]       wdata,
  output logic                    busy,
  output logic [SRC_W-1:0]        cur_src
);

  state_t            state;
  logic [SRC_W-1:0]  rr_ptr;
  logic [DATA_W-1:0] shadow [N_SRC];
  logic [N_SRC-1:0]  valid;
  logic [N_SRC-1:0]  pending;
  logic              pick_any;
  logic [SRC_W-1:0]  pick_idx;
  logic [DATA_W-1:0] pick_dat;

  // A source needs a write if it was never written or has drifted from its shadow.
  always_comb begin
    pending = '0;
    for (int i = 0; i < N_SRC; i++) begin
      pending[i] = !valid[i] || (src_val[i*DATA_W +: DATA_W] != shadow[i]);
    end
  end

  reg_sync_scheduler_rr_pick #(
    .N_SRC (N_SRC),
    .SRC_W (SRC_W)
  ) u_pick (
    .pending (pending),
    .ptr     (rr_ptr),
    .any     (pick_any),
    .idx     (pick_idx)
  );

  assign pick_dat = src_val[int'(pick_idx)*DATA_W +: DATA_W];

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      we_system <= 1'b0;
      waddr     <= '0;
      wdata     <= '0;
      busy      <= 1'b0;
      cur_src   <= '0;
      rr_ptr    <= '0;
      valid     <= '0;
      for (int i = 0; i < N_SRC; i++) shadow[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (en && pick_any) begin
            we_system        <= 1'b1;
            waddr            <= ADDR_W'(src_addr(BASE_ADDR, int'(pick_idx)));
            wdata            <= pick_dat;
            cur_src          <= pick_idx;
            busy             <= 1'b1;
            shadow[pick_idx] <= pick_dat;
            valid[pick_idx]  <= 1'b1;
            state            <= WRITE;
          end else begin
            we_system <= 1'b0;
          end
        end
        WRITE: begin
          if (wr_ready) begin
            we_system <= 1'b0;
            busy      <= 1'b0;
            rr_ptr    <= (cur_src == SRC_W'(N_SRC - 1)) ? '0 : cur_src + 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          we_system <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
      // Placed last so it overrides the valid bit set by a same-cycle grant.
      if (force_sync) valid <= '0;
    end
  end

endmodule

// File: tb/tb_reg_sync_scheduler.sv
// Randomized self-checking bench for reg_sync_scheduler against a transaction-level model.
// Latency: model predicts outputs one edge after the inputs it consumed.
// Backpressure: wr_ready is randomly withheld to stretch writes.
module tb_reg_sync_scheduler;

  localparam int N    = 4;
  localparam int DW   = 32;
  localparam int AW   = 5;
  localparam int BASE = 0;
  localparam int SW   = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic            en;
  logic            force_sync;
  logic [N*DW-1:0] src_val;
  logic            wr_ready;
  logic            we_system;
  logic [AW-1:0]   waddr;
  logic [DW-1:0]   wdata;
  logic            busy;
  logic [SW-1:0]   cur_src;

  always #5 clk = ~clk;

  reg_sync_scheduler #(
    .N_SRC     (N),
    .DATA_W    (DW),
    .ADDR_W    (AW),
    .BASE_ADDR (BASE)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .force_sync (force_sync),
    .src_val    (src_val),
    .wr_ready   (wr_ready),
    .we_system  (we_system),
    .waddr      (waddr),
    .wdata      (wdata),
    .busy       (busy),
    .cur_src    (cur_src)
  );

  int n_chk  = 0;
  int n_pass = 0;
  int n_writes = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  // Reference model: what has been committed to the register file per source,
  // whether that record is trusted, and the in-flight transaction (if any).
  logic [DW-1:0] m_written [N];
  bit            m_trusted [N];
  bit            m_inflight;
  int            m_last;      // source granted most recently; -1 means "none yet"
  bit            m_we;
  int            m_addr, m_src;
  logic [DW-1:0] m_data;

  function automatic logic [DW-1:0] src(input int i);
    return src_val[i*DW +: DW];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_written[i] = '0;
      m_trusted[i] = 0;
    end
    m_inflight = 0; m_last = -1; m_we = 0;
    m_addr = 0; m_src = 0; m_data = '0;
  endtask

  // Applies one clock edge's worth of rules using the inputs present before the edge.
  task automatic model_edge();
    int g;
    if (rst) begin
      model_reset();
      return;
    end
    if (m_inflight) begin
      if (wr_ready) begin
        m_inflight = 0;
        m_we = 0;
        m_last = m_src;
      end
    end else begin
      g = -1;
      if (en) begin
        // Search starts just after the last completed grant, wrapping.
        for (int k = 1; k <= N && g < 0; k++) begin
          int c;
          c = (m_last + k + N) % N;
          if (!m_trusted[c] || m_written[c] != src(c)) g = c;
        end
      end
      if (g >= 0) begin
        m_inflight = 1; m_we = 1;
        m_src = g; m_addr = BASE + g; m_data = src(g);
        m_written[g] = src(g);
        m_trusted[g] = 1;
        n_writes++;
      end else begin
        m_we = 0;
      end
    end
    if (force_sync) for (int i = 0; i < N; i++) m_trusted[i] = 0;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("we_system", 64'(we_system), 64'(m_we));
    chk("busy",      64'(busy),      64'(m_inflight));
    chk("waddr",     64'(waddr),     64'(m_addr));
    chk("wdata",     64'(wdata),     64'(m_data));
    chk("cur_src",   64'(cur_src),   64'(m_src));
  endtask

  task automatic set_src(input int i, input logic [DW-1:0] v);
    src_val[i*DW +: DW] = v;
  endtask

  initial begin
    model_reset();
    rst = 1'b1; en = 1'b1; force_sync = 1'b0; wr_ready = 1'b1; src_val = '0;
    #2;
    step();
    step();
    rst = 1'b0;

    // All-zero sources still get one write each after reset.
    repeat (12) step();

    set_src(2, 32'hDEADBEEF);
    repeat (4) step();

    // Stall a write and change its source mid-flight.
    set_src(1, 32'hA5);
    step();
    wr_ready = 1'b0;
    set_src(1, 32'h1);
    repeat (5) step();
    wr_ready = 1'b1;
    repeat (8) step();

    // Resync everything.
    force_sync = 1'b1;
    step();
    force_sync = 1'b0;
    repeat (12) step();

    // Reset in the middle of a stalled write.
    set_src(0, 32'h55);
    wr_ready = 1'b0;
    repeat (3) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    wr_ready = 1'b1;
    repeat (12) step();

    // Random traffic.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 5) == 0) begin
        if ($urandom_range(0, 1) == 0) set_src($urandom_range(0, N - 1), DW'($urandom_range(0, 3)));
        else set_src($urandom_range(0, N - 1), DW'($urandom));
      end
      wr_ready   = ($urandom_range(0, 3) != 0);
      en         = ($urandom_range(0, 7) != 0);
      force_sync = ($urandom_range(0, 40) == 0);
      rst        = ($urandom_range(0, 250) == 0);
      step();
    end
    rst = 1'b0; force_sync = 1'b0; en = 1'b1; wr_ready = 1'b1;
    repeat (20) step();

    // The stimulus must actually have produced traffic for the comparisons to mean much.
    chk("write_activity", 64'(n_writes > 50), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
